// File: rtl/arith_pkg.sv
// arith_pkg: state encoding shared by the serial arithmetic blocks.
package arith_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_e;
endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(parameter int WIDTH = 8);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   modport slave (input start, a, b, bin, output busy, done, diff, bout);
   modport master (output start, a, b, bin, input busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// full_subtractor: one-bit combinational x - y - bi with borrow-out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);
   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first, one full-subtractor cell
// with a registered borrow; result held until the next accepted start.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic           clk,
   input logic           rst_n,
   serial_subtractor_if.slave io
);
   localparam int CW = $clog2(WIDTH + 1);
   state_e           state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, diff_q, diff_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             br_q, br_d, bout_q, bout_d;
   logic             d, nb;
   full_subtractor u_fs (.x(ra_q[0]), .y(rb_q[0]), .bi(br_q), .d(d), .bo(nb));
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      case (state_q)
         IDLE: if (io.start) begin
            ra_d    = io.a;
            rb_d    = io.b;
            br_d    = io.bin;
            cnt_d   = '0;
            diff_d  = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            diff_d = {d, diff_q[WIDTH-1:1]};
            ra_d   = ra_q >> 1;
            rb_d   = rb_q >> 1;
            br_d   = nb;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               bout_d  = nb;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   // done is decoded straight from the state register, so it is glitch-free
   assign io.busy = state_q != IDLE;
   assign io.done = state_q == DONE;
   assign io.diff = diff_q;
   assign io.bout = bout_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and swept checks of serial_subtractor and its
// full_subtractor cell.
module tb_serial_subtractor;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic fx, fy, fbi, fd, fbo;
   serial_subtractor_if #(.WIDTH(8)) io ();
   serial_subtractor #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .io(io));
   full_subtractor u_fs (.x(fx), .y(fy), .bi(fbi), .d(fd), .bo(fbo));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_done(output int n);
      n = 0;
      while (io.done !== 1'b1 && n < 30) begin
         tick;
         n++;
      end
   endtask
   task automatic op(input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] ed, input logic eb);
      int n;
      io.a = a; io.b = b; io.bin = bin; io.start = 1'b1;
      tick;
      io.start = 1'b0;
      io.a = ~a; io.b = ~b; io.bin = ~bin;
      wait_done(n);
      chk("latency", 32'(n), 32'd8);
      chk("diff", 32'(io.diff), 32'(ed));
      chk("bout", 32'(io.bout), 32'(eb));
      tick;
      chk("done_one_cycle", 32'(io.done), 32'd0);
      chk("busy_after", 32'(io.busy), 32'd0);
      chk("diff_held", 32'(io.diff), 32'(ed));
   endtask
   initial begin
      int n;
      logic seen;
      logic [8:0] r;
      logic [7:0] ra, rb;
      logic rbin;
      rst_n = 1'b0;
      io.start = 1'b0; io.a = '0; io.b = '0; io.bin = 1'b0;
      for (int i = 0; i < 8; i++) begin
         int v;
         {fx, fy, fbi} = 3'(i);
         #1;
         v = int'(fx) - int'(fy) - int'(fbi);
         chk("fs_d", 32'(fd), 32'(v & 1));
         chk("fs_bo", 32'(fbo), 32'(v < 0));
      end
      #12;
      chk("rst_busy", 32'(io.busy), 32'd0);
      chk("rst_done", 32'(io.done), 32'd0);
      chk("rst_diff", 32'(io.diff), 32'd0);
      chk("rst_bout", 32'(io.bout), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      tick;
      op(8'd100, 8'd37, 1'b0, 8'd63, 1'b0);
      op(8'd37, 8'd100, 1'b0, 8'hC1, 1'b1);
      io.a = 8'h00; io.b = 8'h00; io.bin = 1'b1; io.start = 1'b1;
      tick;
      io.a = 8'hFF; io.b = 8'hFF; io.bin = 1'b0;
      wait_done(n);
      chk("b2b_lat", 32'(n), 32'd8);
      chk("b2b_diff0", 32'(io.diff), 32'hFF);
      chk("b2b_bout0", 32'(io.bout), 32'd1);
      n = 0;
      tick;
      n++;
      while (io.done !== 1'b1 && n < 30) begin
         tick;
         n++;
      end
      io.start = 1'b0;
      chk("b2b_spacing", 32'(n), 32'd10);
      chk("b2b_diff1", 32'(io.diff), 32'h00);
      chk("b2b_bout1", 32'(io.bout), 32'd0);
      tick;
      tick;
      io.a = 8'd50; io.b = 8'd20; io.bin = 1'b0; io.start = 1'b1;
      tick;
      io.start = 1'b0; io.a = 8'd1; io.b = 8'd1;
      tick;
      tick;
      io.start = 1'b1;
      tick;
      io.start = 1'b0;
      wait_done(n);
      chk("ign_diff", 32'(io.diff), 32'd30);
      chk("ign_bout", 32'(io.bout), 32'd0);
      io.start = 1'b1;
      tick;
      io.start = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         tick;
         if (io.done === 1'b1) seen = 1'b1;
      end
      chk("ign_no_second_done", 32'(seen), 32'd0);
      chk("ign_busy", 32'(io.busy), 32'd0);
      io.a = 8'd200; io.b = 8'd1; io.bin = 1'b1; io.start = 1'b1;
      tick;
      io.start = 1'b0;
      for (int i = 0; i < 4; i++) tick;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(io.busy), 32'd0);
      chk("mid_rst_done", 32'(io.done), 32'd0);
      chk("mid_rst_diff", 32'(io.diff), 32'd0);
      chk("mid_rst_bout", 32'(io.bout), 32'd0);
      tick;
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick;
         if (io.done === 1'b1) seen = 1'b1;
      end
      chk("mid_rst_no_done", 32'(seen), 32'd0);
      op(8'd9, 8'd3, 1'b0, 8'd6, 1'b0);
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rbin = 1'($urandom);
         r = {1'b0, ra} - {1'b0, rb} - 9'(rbin);
         op(ra, rb, rbin, r[7:0], r[8]);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor computing diff = a - b - bin, LSB first, one bit per clock.
- Wraps one combinational full-subtractor cell with a registered borrow, so area is constant regardless of width.
- It is the inverse-direction counterpart of the team's full-adder arithmetic cells.
- Sits on a start/done handshake beside the adder datapath blocks; result is held until the next operation.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2)
- CW, $clog2(WIDTH+1), bit counter width (derived, not overridden)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- a  in  WIDTH  minuend, captured on accepted start
- b  in  WIDTH  subtrahend, captured on accepted start
- bin  in  1  borrow-in, captured on accepted start
- busy  out  1  high in SHIFT and DONE states
- done  out  1  one-cycle pulse: diff/bout valid
- diff  out  WIDTH  difference, registered, held until next accepted start
- bout  out  1  final borrow-out, registered, held with diff

Behaviour:
- Single clock domain. Reset is asynchronous and active-low; all state is cleared while rst_n=0.
- Reset values: state=IDLE, busy=0, done=0, diff=0, bout=0, count=0, internal operand and borrow registers=0.
- FSM states:
  - IDLE: start=1 latches a→ra, b→rb, bin→br, count=0, diff cleared to 0, then moves to SHIFT.
  - SHIFT: each cycle computes d = ra[0]^rb[0]^br and nb = (~ra[0]&rb[0]) | (~(ra[0]^rb[0])&br).
    - diff <= {d, diff[WIDTH-1:1]}; ra, rb shift right by 1; br <= nb; count++.
    - When count==WIDTH-1 on a shifting edge, the state moves to DONE; bout <= nb and done <= 1 on the same edge.
  - DONE: done=1 for exactly this one cycle, then unconditional move to IDLE.
- Latency: the start-accept edge is edge k. Bits are processed on edges k+1..k+WIDTH, and done is high in the cycle following edge k+WIDTH.
  - Throughput: one operation per WIDTH+2 cycles.
- start while busy=1 (SHIFT or DONE) is ignored. There is no queueing; the operands on the ports at that time are not captured.
- start held high continuously: a new operation is accepted on each return to IDLE.
- a, b, and bin may change freely after the accept edge; only the captured copies are used.
- Arithmetic is modulo 2^WIDTH. bout=1 iff a < b + bin as unsigned values.
- Reset mid-operation: all outputs return to reset values immediately. The partial result is discarded and done does not fire.
- diff is intermediate (partially shifted) during SHIFT. Consumers use it only when done=1 or after done while busy=0.

Decomposition:
- Shared package arith_pkg holds the state encoding typedef: IDLE=2'b00, SHIFT=2'b01, DONE=2'b10.
- Natural sub-module: full_subtractor (inputs x, y, bi; outputs d, bo), purely combinational, instantiated once.
  - Its equations are exactly d and nb above. It must be verified standalone over all 8 input combinations.

Test Plan:
- WIDTH=8, a=100, b=37, bin=0, start pulse → done high 8 edges after the accept edge (one cycle only); diff=63, bout=0; busy low the following cycle.
- a=37, b=100, bin=0 → diff=193 (8'hC1), bout=1.
- a=0, b=0, bin=1 → diff=8'hFF, bout=1. Then a=8'hFF, b=8'hFF, bin=0 → diff=0, bout=0. Both run back-to-back with start held high, checking the WIDTH+2 cycle spacing.
- Accept a=50, b=20; pulse start with a=1, b=1 three cycles later and again during DONE → first result diff=30, bout=0; no second done; busy=0 afterward.
- Assert rst_n=0 for one cycle after 4 shift cycles → busy, done, diff, and bout go to 0 immediately; no done pulse; a fresh start (a=9, b=3) then yields diff=6.
- Randomised sweep of 1000 (a, b, bin) triples against the reference model {bout,diff} = {1'b0,a} - {1'b0,b} - bin, with bout taken from bit WIDTH of the result.
